game_flow_ctrl: RTL and testbench

- Parametrised game-flow sequencer for the snake top level. Replaces the single-shot gate that combined start, apple-ready, failure and success into one tick enable, and the sticky failure/success flags.
- Adds multiple lives, score and level counters, a level-dependent tick period counted in frames, explicit pause, and dropped-tick accounting.
- Sits between the vsync frame pulse and the snake/apple blocks, and drives state to vga.

---
 rtl/game_flow_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: paces snake ticks from vsync frames and tracks lives, score, level and dropped ticks.
// All outputs are registered; o_tick follows the frame boundary by one cycle.
module game_flow_ctrl #(
    parameter int LIVES            = 3,
    parameter int SCORE_W          = 8,
    parameter int LEVEL_W          = 3,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int BASE_PERIOD      = 16,
    parameter int PERIOD_STEP      = 2,
    parameter int MIN_PERIOD       = 2,
    parameter int DEATH_FRAMES     = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_restart,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_frame,
    input  logic               i_ready,
    input  logic               i_tick_done,
    input  logic               i_eat,
    input  logic               i_failure,
    input  logic               i_success,
    output logic               o_tick,
    output logic               o_round_rst,
    output logic [2:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic [LEVEL_W-1:0] o_level,
    output logic [2:0]         o_lives,
    output logic [7:0]         o_dropped
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DYING = 3'd3,
        OVER  = 3'd4,
        WON   = 3'd5
    } state_t;

    localparam logic [15:0] SPAN = 16'(BASE_PERIOD - MIN_PERIOD);

    state_t             state, state_n;
    logic [7:0]         frame_cnt, frame_cnt_n;
    logic [7:0]         period_q, period_q_n;
    logic [7:0]         apple_cnt, apple_cnt_n;
    logic               busy, busy_n;
    logic [SCORE_W-1:0] score, score_n;
    logic [LEVEL_W-1:0] level, level_n;
    logic [2:0]         lives, lives_n;
    logic [7:0]         dropped, dropped_n;
    logic               tick, tick_n;
    logic               round_rst, round_rst_n;

    logic [15:0]        lvl_step;
    logic [7:0]         period;
    logic [7:0]         frame_inc;
    logic [7:0]         apple_inc;
    logic               busy_eff;

    // Compared in 16 bits so a large level never wraps below the floor.
    assign lvl_step = 16'(level) * 16'(PERIOD_STEP);

    always_comb begin
        if (lvl_step >= SPAN) begin
            period = 8'(MIN_PERIOD);
        end else begin
            period = 8'(BASE_PERIOD) - lvl_step[7:0];
        end
    end

    assign frame_inc = frame_cnt + 8'd1;
    assign apple_inc = apple_cnt + 8'd1;
    assign busy_eff  = busy & ~i_tick_done;

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        period_q_n  = period_q;
        apple_cnt_n = apple_cnt;
        busy_n      = busy;
        score_n     = score;
        level_n     = level;
        lives_n     = lives;
        dropped_n   = dropped;
        tick_n      = 1'b0;
        round_rst_n = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n     = RUN;
                    frame_cnt_n = 8'd0;
                    period_q_n  = period;
                end
            end
            RUN, PAUSE: begin
                busy_n = busy_eff;
                if (state == RUN) begin
                    if (i_pause) begin
                        state_n = PAUSE;
                    end else if (i_frame) begin
                        // Period is sampled at each boundary so a level-up takes effect one interval later.
                        if (frame_inc >= period_q) begin
                            frame_cnt_n = 8'd0;
                            period_q_n  = period;
                            if (!busy_eff && i_ready) begin
                                tick_n = 1'b1;
                                busy_n = 1'b1;
                            end else if (dropped != 8'hFF) begin
                                dropped_n = dropped + 8'd1;
                            end
                        end else begin
                            frame_cnt_n = frame_inc;
                        end
                    end
                end else if (!i_pause) begin
                    state_n = RUN;
                end

                if (i_eat) begin
                    if (score != {SCORE_W{1'b1}}) begin
                        score_n = score + SCORE_W'(1);
                    end
                    if (apple_inc >= 8'(APPLES_PER_LEVEL)) begin
                        apple_cnt_n = 8'd0;
                        if (level != {LEVEL_W{1'b1}}) begin
                            level_n = level + LEVEL_W'(1);
                        end
                    end else begin
                        apple_cnt_n = apple_inc;
                    end
                end

                if (i_failure) begin
                    lives_n = lives - 3'd1;
                    busy_n  = 1'b0;
                    tick_n  = 1'b0;
                    if (lives == 3'd1) begin
                        state_n = OVER;
                    end else begin
                        state_n     = DYING;
                        frame_cnt_n = 8'd0;
                    end
                end else if (i_success) begin
                    state_n = WON;
                    busy_n  = 1'b0;
                    tick_n  = 1'b0;
                end
            end
            DYING: begin
                if (i_frame) begin
                    if (frame_inc >= 8'(DEATH_FRAMES)) begin
                        round_rst_n = 1'b1;
                        busy_n      = 1'b0;
                        frame_cnt_n = 8'd0;
                        state_n     = IDLE;
                    end else begin
                        frame_cnt_n = frame_inc;
                    end
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_restart) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
            period_q  <= 8'(BASE_PERIOD);
            apple_cnt <= 8'd0;
            busy      <= 1'b0;
            score     <= '0;
            level     <= '0;
            lives     <= 3'(LIVES);
            dropped   <= 8'd0;
            tick      <= 1'b0;
            round_rst <= 1'b0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            period_q  <= period_q_n;
            apple_cnt <= apple_cnt_n;
            busy      <= busy_n;
            score     <= score_n;
            level     <= level_n;
            lives     <= lives_n;
            dropped   <= dropped_n;
            tick      <= tick_n;
            round_rst <= round_rst_n;
        end
    end

    assign o_tick      = tick;
    assign o_round_rst = round_rst;
    assign o_state     = state;
    assign o_score     = score;
    assign o_level     = level;
    assign o_lives     = lives;
    assign o_dropped   = dropped;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: inputs change on falling edges, outputs sampled on the next falling edge.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, i_restart, i_start, i_pause, i_frame, i_ready;
    logic       i_tick_done, i_eat, i_failure, i_success;
    logic       o_tick, o_round_rst;
    logic [2:0] o_state, o_lives;
    logic [7:0] o_score, o_dropped;
    logic [2:0] o_level;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_restart  (i_restart),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_frame    (i_frame),
        .i_ready    (i_ready),
        .i_tick_done(i_tick_done),
        .i_eat      (i_eat),
        .i_failure  (i_failure),
        .i_success  (i_success),
        .o_tick     (o_tick),
        .o_round_rst(o_round_rst),
        .o_state    (o_state),
        .o_score    (o_score),
        .o_level    (o_level),
        .o_lives    (o_lives),
        .o_dropped  (o_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given frame/done pulses; one-shot inputs are dropped afterwards.
    task automatic step(input logic f, input logic d);
        i_frame     = f;
        i_tick_done = d;
        @(negedge clk);
        i_frame     = 1'b0;
        i_tick_done = 1'b0;
        i_start     = 1'b0;
        i_eat       = 1'b0;
        i_failure   = 1'b0;
        i_success   = 1'b0;
        i_restart   = 1'b0;
    endtask

    task automatic frame(input bit auto_done, output bit ticked, output bit rr);
        step(1'b1, 1'b0);
        ticked = o_tick;
        rr     = o_round_rst;
        if (ticked && auto_done) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic run_check(input string tag, input int n, input int per);
        bit t, r;
        for (int f = 1; f <= n; f++) begin
            frame(1'b1, t, r);
            chk(tag, 32'(t), 32'(f % per == 0));
        end
    endtask

    task automatic die_wait();
        bit t, r;
        int rrc = 0;
        for (int f = 1; f <= 60; f++) begin
            frame(1'b0, t, r);
            rrc += int'(r);
        end
        chk("round_rst_pulses", 32'(rrc), 1);
        chk("dying_exit_state", 32'(o_state), 0);
    endtask

    task automatic start_round();
        i_start = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic fail_once();
        i_failure = 1'b1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        bit t, r;
        int tcnt;
        rst_n = 1'b0; i_restart = 1'b0; i_start = 1'b0; i_pause = 1'b0;
        i_frame = 1'b0; i_ready = 1'b1; i_tick_done = 1'b0;
        i_eat = 1'b0; i_failure = 1'b0; i_success = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        chk("rst_state", 32'(o_state), 0);
        chk("rst_lives", 32'(o_lives), 3);
        chk("rst_score", 32'(o_score), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_tick", 32'(o_tick), 0);
        chk("rst_dropped", 32'(o_dropped), 0);
        chk("rst_round_rst", 32'(o_round_rst), 0);

        // IDLE ignores frames.
        frame(1'b1, t, r);
        chk("idle_no_tick", 32'(t), 0);
        start_round();
        chk("start_run", 32'(o_state), 1);

        run_check("base_tick", 48, 16);
        chk("base_dropped", 32'(o_dropped), 0);

        // Done withheld from the tick at frame 16 until after frame 48.
        for (int f = 1; f <= 64; f++) begin
            frame(f > 48, t, r);
            chk("withheld_tick", 32'(t), 32'(f == 16 || f == 64));
            if (f == 32) chk("dropped_32", 32'(o_dropped), 1);
            if (f == 48) begin
                chk("dropped_48", 32'(o_dropped), 2);
                step(1'b0, 1'b1);
            end
        end
        chk("dropped_final", 32'(o_dropped), 2);

        repeat (8) begin
            i_eat = 1'b1;
            step(1'b0, 1'b0);
        end
        chk("score_8", 32'(o_score), 8);
        chk("level_2", 32'(o_level), 2);
        run_check("old_period", 16, 16);
        run_check("period_12", 12, 12);

        repeat (24) begin
            i_eat = 1'b1;
            step(1'b0, 1'b0);
        end
        chk("score_32", 32'(o_score), 32);
        chk("level_sat", 32'(o_level), 7);
        run_check("period_12_again", 12, 12);
        run_check("period_floor", 4, 2);

        fail_once();
        chk("fail1_lives", 32'(o_lives), 2);
        chk("fail1_state", 32'(o_state), 3);
        die_wait();
        chk("keep_score", 32'(o_score), 32);
        chk("keep_level", 32'(o_level), 7);
        start_round();
        fail_once();
        chk("fail2_lives", 32'(o_lives), 1);
        die_wait();
        start_round();
        fail_once();
        chk("fail3_lives", 32'(o_lives), 0);
        chk("fail3_over", 32'(o_state), 4);
        start_round();
        chk("over_ignores_start", 32'(o_state), 4);
        i_eat = 1'b1;
        step(1'b0, 1'b0);
        chk("over_ignores_eat", 32'(o_score), 32);
        frame(1'b1, t, r);
        chk("over_no_tick", 32'(t), 0);

        i_restart = 1'b1;
        step(1'b0, 1'b0);
        chk("restart_state", 32'(o_state), 0);
        chk("restart_lives", 32'(o_lives), 3);
        chk("restart_score", 32'(o_score), 0);
        start_round();
        fail_once();
        die_wait();
        start_round();
        fail_once();
        die_wait();
        start_round();
        chk("one_life", 32'(o_lives), 1);
        i_eat = 1'b1; i_failure = 1'b1; i_success = 1'b1;
        step(1'b0, 1'b0);
        chk("same_cycle_score", 32'(o_score), 1);
        chk("same_cycle_state", 32'(o_state), 4);
        chk("same_cycle_lives", 32'(o_lives), 0);

        i_restart = 1'b1;
        step(1'b0, 1'b0);
        start_round();
        run_check("pre_pause", 10, 16);
        i_pause = 1'b1;
        step(1'b0, 1'b0);
        chk("pause_state", 32'(o_state), 2);
        i_eat = 1'b1;
        step(1'b0, 1'b0);
        chk("pause_eat", 32'(o_score), 1);
        tcnt = 0;
        for (int f = 1; f <= 30; f++) begin
            frame(1'b1, t, r);
            tcnt += int'(t);
        end
        chk("pause_ticks", 32'(tcnt), 0);
        chk("pause_hold", 32'(o_state), 2);
        i_pause = 1'b0;
        step(1'b0, 1'b0);
        chk("unpause_state", 32'(o_state), 1);
        run_check("post_pause", 6, 6);

        fail_once();
        chk("dying_state", 32'(o_state), 3);
        repeat (5) frame(1'b0, t, r);
        i_restart = 1'b1;
        step(1'b0, 1'b0);
        chk("rs_state", 32'(o_state), 0);
        chk("rs_lives", 32'(o_lives), 3);
        chk("rs_score", 32'(o_score), 0);
        chk("rs_level", 32'(o_level), 0);
        chk("rs_dropped", 32'(o_dropped), 0);
        chk("rs_tick", 32'(o_tick), 0);
        chk("rs_round_rst", 32'(o_round_rst), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
